// File: rtl/hazard_pkg.sv
// Shared types and constants for the stall/flush hazard unit and its MDU tracker.
package hazard_pkg;

  localparam int MDU_LAT_DEFAULT = 4;
  localparam int CNT_W_DEFAULT   = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // True when a real (non-x0) destination feeds either source operand.
  function automatic logic src_hit(input logic [4:0] rd,
                                   input logic [4:0] rs1,
                                   input logic [4:0] rs2);
    return (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/mdu_tracker.sv
// Tracks the single in-flight multi-cycle mul/div op: latency counter, destination and
// registered busy/done flags.
module mdu_tracker
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic [4:0] issue_rd,
  output logic       busy,
  output logic [4:0] rd,
  output logic       done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rd    <= REG_ZERO;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
            rd    <= issue_rd;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          // An issue here is illegal and ignored; the assertion below reports it.
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (issue) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
            rd    <= issue_rd;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  issue_while_busy: assert property (@(posedge clk) disable iff (rst)
    !((state == BUSY) && issue))
    else $error("mdu_tracker: MDU op issued while previous op still busy");

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for load-use, branch redirect and multi-cycle MDU hazards that
// operand forwarding cannot resolve.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_addr_D,
  input  logic [4:0] rs2_addr_D,
  input  logic [4:0] RdD,
  input  logic       RegWriteD,
  input  logic       MulDivD,
  input  logic [4:0] RdE,
  input  logic       LoadE,
  input  logic       MulDivE,
  input  logic       PCSrcE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       mdu_busy,
  output logic [4:0] mdu_rd,
  output logic       mdu_done
);

  logic lw_stall;
  logic md_stall;

  // Ops already in Execute are committed, so a taken branch never cancels the tracker.
  mdu_tracker #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_tracker (
    .clk      (clk),
    .rst      (rst),
    .issue    (MulDivE),
    .issue_rd (RdE),
    .busy     (mdu_busy),
    .rd       (mdu_rd),
    .done     (mdu_done)
  );

  assign lw_stall = LoadE && src_hit(RdE, rs1_addr_D, rs2_addr_D);

  // RAW on sources, WAW on destination, or structural conflict on the MDU itself.
  // On the done cycle the result is forwardable, so no stall is raised.
  assign md_stall = mdu_busy && !mdu_done &&
                    (src_hit(mdu_rd, rs1_addr_D, rs2_addr_D) ||
                     (RegWriteD && (mdu_rd != REG_ZERO) && (mdu_rd == RdD)) ||
                     MulDivD);

  // NOTE: every output gets a default first so no path through the if-chain infers a latch.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      // Hold all controls low while reset is asserted.
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall || md_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

endmodule
